// File: rtl/sysctrl_pkg.sv
// sysctrl_pkg
// Shared definitions for the MCU system-control byte protocol: command codes,
// status signature bytes, host and boot sequencer state types, and the boot
// ROM contents used by sysctrl_host_boot (SYSCTRL_HOST_BOOT_EN builds).
package sysctrl_pkg;

  localparam logic [7:0] CMD_STATUS   = 8'd0;
  localparam logic [7:0] CMD_LED      = 8'd1;
  localparam logic [7:0] CMD_COLOR    = 8'd2;
  localparam logic [7:0] CMD_BUTTONS  = 8'd3;
  localparam logic [7:0] CMD_CONFIG   = 8'd4;
  localparam logic [7:0] CMD_INT_CTRL = 8'd5;
  localparam logic [7:0] CMD_INT_SRC  = 8'd6;
  localparam logic [7:0] CMD_PORT     = 8'd7;
  localparam logic [7:0] CMD_MENU     = 8'd8;

  localparam logic [7:0] STATUS_SIG0  = 8'h5C;
  localparam logic [7:0] STATUS_SIG1  = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_FETCH,
    S_BYTE,
    S_DONE
  } host_state_t;

  typedef enum logic [2:0] {
    BT_START,
    BT_REQ,
    BT_XFER,
    BT_OK,
    BT_FAIL
  } boot_state_t;

  // One boot request: command, payload length, first payload ROM index.
  typedef struct packed {
    logic [7:0] cmd;
    logic [3:0] len;
    logic [2:0] base;
  } boot_step_t;

  localparam logic [1:0] BOOT_LAST_STEP = 2'd2;

  function automatic boot_step_t boot_step(input logic [1:0] idx);
    boot_step_t s;
    case (idx)
      2'd0:    s = '{cmd: CMD_STATUS,   len: 4'd3, base: 3'd0};
      2'd1:    s = '{cmd: CMD_CONFIG,   len: 4'd2, base: 3'd3};
      default: s = '{cmd: CMD_INT_CTRL, len: 4'd1, base: 3'd5};
    endcase
    return s;
  endfunction

  // Flattened payload ROM: status probe {0,0,0}, release reset {"R",0},
  // ack coldboot interrupt {1}.
  function automatic logic [7:0] boot_payload(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd3:    b = 8'h52;
      3'd5:    b = 8'h01;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sysctrl_host_boot.sv
// sysctrl_host_boot
// ROM-driven boot sequencer, built only with SYSCTRL_HOST_BOOT_EN. After reset
// it probes the responder status signature, then releases the system reset
// and acks the coldboot interrupt. It drives the host core's request/payload
// inputs while o_active is high.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_req_ready, i_tx_ready         core handshakes
//   i_rx_valid, i_rx_data, i_done   core response stream / completion
//   o_active                        sequencer owns the core inputs
//   o_req_*, o_tx_*                 request and payload towards the core
//   o_boot_ok, o_boot_fail          final sequence result
module sysctrl_host_boot
  import sysctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_req_ready,
  input  logic       i_tx_ready,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_done,
  output logic       o_active,
  output logic       o_req_valid,
  output logic [7:0] o_req_cmd,
  output logic [3:0] o_req_len,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  output logic       o_boot_ok,
  output logic       o_boot_fail
);

  boot_state_t r_state;
  logic [1:0]  r_step;
  logic [2:0]  r_pidx;
  logic [3:0]  r_left;
  logic [1:0]  r_rx_idx;
  logic        r_mismatch;
  logic        r_active;
  logic        r_req_valid;
  logic [7:0]  r_req_cmd;
  logic [3:0]  r_req_len;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_boot_ok;
  logic        r_boot_fail;

  boot_step_t  w_step;
  logic        w_bad;

  assign w_step = boot_step(r_step);

  // Only the first two status bytes carry the signature.
  always_comb begin
    w_bad = 1'b0;
    if (i_rx_valid && r_step == 2'd0) begin
      if (r_rx_idx == 2'd0 && i_rx_data != STATUS_SIG0) w_bad = 1'b1;
      if (r_rx_idx == 2'd1 && i_rx_data != STATUS_SIG1) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= BT_START;
      r_step      <= '0;
      r_pidx      <= '0;
      r_left      <= '0;
      r_rx_idx    <= '0;
      r_mismatch  <= 1'b0;
      r_active    <= 1'b1;
      r_req_valid <= 1'b0;
      r_req_cmd   <= '0;
      r_req_len   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_boot_ok   <= 1'b0;
      r_boot_fail <= 1'b0;
    end else begin
      case (r_state)
        BT_START: begin
          r_req_valid <= 1'b1;
          r_req_cmd   <= w_step.cmd;
          r_req_len   <= w_step.len;
          r_pidx      <= w_step.base;
          r_left      <= w_step.len;
          r_rx_idx    <= '0;
          r_mismatch  <= 1'b0;
          r_state     <= BT_REQ;
        end
        BT_REQ: begin
          if (i_req_ready) begin
            r_req_valid <= 1'b0;
            r_tx_valid  <= (r_left != '0);
            r_tx_data   <= boot_payload(r_pidx);
            r_state     <= BT_XFER;
          end
        end
        BT_XFER: begin
          if (r_tx_valid && i_tx_ready) begin
            r_pidx    <= r_pidx + 3'd1;
            r_left    <= r_left - 4'd1;
            r_tx_data <= boot_payload(r_pidx + 3'd1);
            if (r_left == 4'd1) r_tx_valid <= 1'b0;
          end
          if (i_rx_valid) begin
            r_rx_idx <= r_rx_idx + 2'd1;
            if (w_bad) r_mismatch <= 1'b1;
          end
          if (i_done) begin
            if (r_step == 2'd0 && (r_mismatch || w_bad)) begin
              r_boot_fail <= 1'b1;
              r_active    <= 1'b0;
              r_state     <= BT_FAIL;
            end else if (r_step == BOOT_LAST_STEP) begin
              r_boot_ok <= 1'b1;
              r_active  <= 1'b0;
              r_state   <= BT_OK;
            end else begin
              r_step  <= r_step + 2'd1;
              r_state <= BT_START;
            end
          end
        end
        BT_OK:   r_state <= BT_OK;
        BT_FAIL: r_state <= BT_FAIL;
        default: r_state <= BT_FAIL;
      endcase
    end
  end

  assign o_active    = r_active;
  assign o_req_valid = r_req_valid;
  assign o_req_cmd   = r_req_cmd;
  assign o_req_len   = r_req_len;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_data   = r_tx_data;
  assign o_boot_ok   = r_boot_ok;
  assign o_boot_fail = r_boot_fail;

endmodule

// File: rtl/sysctrl_host.sv
// sysctrl_host
// FPGA-side initiator for the MCU system-control byte protocol. Emits a start
// strobe with the command byte, then one strobe per payload byte, and returns
// the responder's data_out byte sampled GAP cycles after each payload strobe.
// Optional boot sequencer: define SYSCTRL_HOST_BOOT_EN.
// Parameters: GAP (2..255) cycles from strobe to data_out sample point.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req_valid/req_ready/req_cmd/req_len request handshake (ready in IDLE only)
//   tx_valid/tx_ready/tx_data           payload byte stream
//   rx_valid/rx_data/rx_last            response byte stream
//   done, busy                          completion pulse, non-IDLE status
//   data_in_strobe/data_in_start/data_in  byte stream to the responder
//   data_out, int_out_n                 responder return byte and interrupt
//   irq_pending                         int_out_n synchronised and inverted
//   boot_ok, boot_fail                  boot result (boot build only)
module sysctrl_host
  import sysctrl_pkg::*;
#(
  parameter int unsigned GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [3:0] req_len,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic       done,
  output logic       busy,
  output logic       data_in_strobe,
  output logic       data_in_start,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  input  logic       int_out_n,
  output logic       irq_pending
`ifdef SYSCTRL_HOST_BOOT_EN
  ,
  output logic       boot_ok,
  output logic       boot_fail
`endif
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  host_state_t r_state;
  logic [3:0]  r_len;
  logic [3:0]  r_cnt;
  logic [7:0]  r_gap;
  logic        r_req_ready;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        r_rx_last;
  logic        r_done;
  logic        r_busy;
  logic        r_strobe;
  logic        r_start;
  logic [7:0]  r_data_in;
  logic        r_irq_meta;
  logic        r_irq_pending;

  logic        w_req_valid;
  logic [7:0]  w_req_cmd;
  logic [3:0]  w_req_len;
  logic        w_tx_valid;
  logic [7:0]  w_tx_data;
  logic        w_tx_ready;

  assign w_tx_ready = (r_state == S_FETCH) && w_tx_valid;

`ifdef SYSCTRL_HOST_BOOT_EN
  logic       w_boot_active;
  logic       w_boot_req_valid;
  logic [7:0] w_boot_req_cmd;
  logic [3:0] w_boot_req_len;
  logic       w_boot_tx_valid;
  logic [7:0] w_boot_tx_data;

  sysctrl_host_boot u_boot (
    .clk         (clk),
    .reset       (reset),
    .i_req_ready (r_req_ready),
    .i_tx_ready  (w_tx_ready),
    .i_rx_valid  (r_rx_valid),
    .i_rx_data   (r_rx_data),
    .i_done      (r_done),
    .o_active    (w_boot_active),
    .o_req_valid (w_boot_req_valid),
    .o_req_cmd   (w_boot_req_cmd),
    .o_req_len   (w_boot_req_len),
    .o_tx_valid  (w_boot_tx_valid),
    .o_tx_data   (w_boot_tx_data),
    .o_boot_ok   (boot_ok),
    .o_boot_fail (boot_fail)
  );

  assign w_req_valid = w_boot_active ? w_boot_req_valid : req_valid;
  assign w_req_cmd   = w_boot_active ? w_boot_req_cmd   : req_cmd;
  assign w_req_len   = w_boot_active ? w_boot_req_len   : req_len;
  assign w_tx_valid  = w_boot_active ? w_boot_tx_valid  : tx_valid;
  assign w_tx_data   = w_boot_active ? w_boot_tx_data   : tx_data;
  assign req_ready   = r_req_ready && !w_boot_active;
  assign tx_ready    = w_tx_ready  && !w_boot_active;
`else
  assign w_req_valid = req_valid;
  assign w_req_cmd   = req_cmd;
  assign w_req_len   = req_len;
  assign w_tx_valid  = tx_valid;
  assign w_tx_data   = tx_data;
  assign req_ready   = r_req_ready;
  assign tx_ready    = w_tx_ready;
`endif

  // Outputs are registered on the transition into the state they belong to,
  // so strobe is high during CMD/BYTE and done is high during DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_req_ready <= 1'b1;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_rx_last   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_strobe    <= 1'b0;
      r_start     <= 1'b0;
      r_data_in   <= '0;
    end else begin
      r_strobe   <= 1'b0;
      r_start    <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_last  <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_valid) begin
            r_len       <= w_req_len;
            r_cnt       <= '0;
            r_data_in   <= w_req_cmd;
            r_strobe    <= 1'b1;
            r_start     <= 1'b1;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_CMD;
          end
        end
        S_CMD: begin
          r_gap   <= GAP_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_gap == '0) begin
            // A non-zero count means the last strobe carried payload byte r_cnt.
            if (r_cnt != '0) begin
              r_rx_data  <= data_out;
              r_rx_valid <= 1'b1;
              r_rx_last  <= (r_cnt == r_len);
            end
            if (r_cnt < r_len) begin
              r_state <= S_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        S_FETCH: begin
          if (w_tx_valid) begin
            r_data_in <= w_tx_data;
            r_strobe  <= 1'b1;
            r_state   <= S_BYTE;
          end
        end
        S_BYTE: begin
          r_cnt   <= r_cnt + 4'd1;
          r_gap   <= GAP_LOAD;
          r_state <= S_WAIT;
        end
        S_DONE: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_meta    <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_irq_meta    <= !int_out_n;
      r_irq_pending <= r_irq_meta;
    end
  end

  assign rx_valid       = r_rx_valid;
  assign rx_data        = r_rx_data;
  assign rx_last        = r_rx_last;
  assign done           = r_done;
  assign busy           = r_busy;
  assign data_in_strobe = r_strobe;
  assign data_in_start  = r_start;
  assign data_in        = r_data_in;
  assign irq_pending    = r_irq_pending;

endmodule
